// File: rtl/expand_32x8b_16b.sv
// expand_32x8b_16b: re-expands 32 lanes of int8 activations into int16 accumulator Q format.
// Two-stage valid/ready pipeline: S1 shifts/rounds, S2 saturates and tracks saturation stats.
module expand_32x8b_16b #(
    parameter int LANES = 32,
    parameter int IW    = 8,
    parameter int OW    = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [3:0]            i_q_encode,
    input  logic [3:0]            w_q_encode,
    input  logic [3:0]            o_q_encode,
    input  logic [1:0]            i_round_mode,
    input  logic                  i_cfg_load,
    input  logic                  i_dat_vld,
    output logic                  o_dat_rdy,
    input  logic [LANES*IW-1:0]   i_dat,
    output logic                  o_dat_vld,
    input  logic                  i_dat_rdy,
    output logic [LANES*OW-1:0]   o_dat,
    input  logic                  i_sat_clr,
    output logic                  o_sat_flag,
    output logic [15:0]           o_sat_cnt
);
    localparam int MW = IW + OW;
    localparam logic signed [MW-1:0] MAXV = MW'((1 << (OW - 1)) - 1);
    localparam logic signed [MW-1:0] MINV = ~MAXV;
    localparam logic [5:0] LCAP = 6'(OW);

    logic [5:0]              r_shift;
    logic [1:0]              r_mode;
    logic                    r_s1_vld;
    logic                    r_s1_pos;
    logic signed [MW-1:0]    r_s1_dat [LANES];
    logic                    r_s2_vld;
    logic [LANES*OW-1:0]     r_s2_dat;
    logic                    r_s2_sat;
    logic                    r_sat_flag;
    logic [15:0]             r_sat_cnt;

    logic [5:0]              w_s;
    logic [4:0]              w_lsh;
    logic [4:0]              w_rsh;
    logic signed [MW-1:0]    w_rnd;
    logic signed [MW-1:0]    w_ext [LANES];
    logic signed [MW-1:0]    w_s1 [LANES];
    logic [LANES*OW-1:0]     w_s2_dat;
    logic                    w_s2_sat;
    logic                    w_s2_adv;
    logic                    w_out_hs;

    assign w_s = {2'b00, i_q_encode} + {2'b00, w_q_encode} - {2'b00, o_q_encode};

    assign w_s2_adv  = !r_s2_vld || i_dat_rdy;
    assign o_dat_rdy = !r_s1_vld || w_s2_adv;
    assign w_out_hs  = r_s2_vld && i_dat_rdy;

    assign o_dat_vld  = r_s2_vld;
    assign o_dat      = r_s2_dat;
    assign o_sat_flag = r_sat_flag;
    assign o_sat_cnt  = r_sat_cnt;

    // Left shifts beyond OW saturate identically, so clamp the amount to keep MW bits exact.
    always_comb begin
        w_lsh = '0;
        w_rsh = '0;
        if (!r_shift[5]) begin
            w_lsh = (r_shift > LCAP) ? LCAP[4:0] : r_shift[4:0];
        end else begin
            w_rsh = 5'(6'd0 - r_shift);
        end
    end

    always_comb begin
        w_rnd = '0;
        if (r_shift[5] && r_mode == 2'd1) begin
            w_rnd = {{(MW-1){1'b0}}, 1'b1} << (w_rsh - 5'd1);
        end
        for (int k = 0; k < LANES; k++) begin
            w_ext[k] = {{(MW-IW){i_dat[k*IW+IW-1]}}, i_dat[k*IW +: IW]};
            if (r_shift[5]) begin
                w_s1[k] = (w_ext[k] + w_rnd) >>> w_rsh;
            end else begin
                w_s1[k] = w_ext[k] <<< w_lsh;
            end
        end
    end

    always_comb begin
        w_s2_dat = '0;
        w_s2_sat = 1'b0;
        for (int k = 0; k < LANES; k++) begin
            if (r_s1_dat[k] > MAXV) begin
                w_s2_dat[k*OW +: OW] = MAXV[OW-1:0];
                w_s2_sat = w_s2_sat | r_s1_pos;
            end else if (r_s1_dat[k] < MINV) begin
                w_s2_dat[k*OW +: OW] = MINV[OW-1:0];
                w_s2_sat = w_s2_sat | r_s1_pos;
            end else begin
                w_s2_dat[k*OW +: OW] = r_s1_dat[k][OW-1:0];
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_shift  <= '0;
            r_mode   <= '0;
            r_s1_vld <= 1'b0;
            r_s1_pos <= 1'b0;
            for (int k = 0; k < LANES; k++) begin
                r_s1_dat[k] <= '0;
            end
        end else begin
            if (i_cfg_load) begin
                r_shift <= w_s;
                r_mode  <= i_round_mode;
            end
            if (o_dat_rdy) begin
                r_s1_vld <= i_dat_vld;
                if (i_dat_vld) begin
                    r_s1_pos <= !r_shift[5];
                    r_s1_dat <= w_s1;
                end
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_s2_vld <= 1'b0;
            r_s2_dat <= '0;
            r_s2_sat <= 1'b0;
        end else if (w_s2_adv) begin
            r_s2_vld <= r_s1_vld;
            if (r_s1_vld) begin
                r_s2_dat <= w_s2_dat;
                r_s2_sat <= w_s2_sat;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sat_flag <= 1'b0;
            r_sat_cnt  <= '0;
        end else if (i_sat_clr) begin
            r_sat_flag <= 1'b0;
            r_sat_cnt  <= '0;
        end else if (w_out_hs && r_s2_sat) begin
            r_sat_flag <= 1'b1;
            if (r_sat_cnt != 16'hFFFF) begin
                r_sat_cnt <= r_sat_cnt + 16'd1;
            end
        end
    end
endmodule

// File: tb/tb_expand_32x8b_16b.sv
// tb_expand_32x8b_16b: directed self-checking bench for expand_32x8b_16b.
// Each task drives one scenario and compares against hand-computed values.
module tb_expand_32x8b_16b;
    logic         clk = 1'b0;
    logic         i_rst;
    logic [3:0]   i_q_encode, w_q_encode, o_q_encode;
    logic [1:0]   i_round_mode;
    logic         i_cfg_load;
    logic         i_dat_vld;
    logic         o_dat_rdy;
    logic [255:0] i_dat;
    logic         o_dat_vld;
    logic         i_dat_rdy;
    logic [511:0] o_dat;
    logic         i_sat_clr;
    logic         o_sat_flag;
    logic [15:0]  o_sat_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    expand_32x8b_16b dut (
        .i_clk(clk), .i_rst(i_rst),
        .i_q_encode(i_q_encode), .w_q_encode(w_q_encode), .o_q_encode(o_q_encode),
        .i_round_mode(i_round_mode), .i_cfg_load(i_cfg_load),
        .i_dat_vld(i_dat_vld), .o_dat_rdy(o_dat_rdy), .i_dat(i_dat),
        .o_dat_vld(o_dat_vld), .i_dat_rdy(i_dat_rdy), .o_dat(o_dat),
        .i_sat_clr(i_sat_clr), .o_sat_flag(o_sat_flag), .o_sat_cnt(o_sat_cnt)
    );

    task automatic load_cfg(input logic [3:0] iq, input logic [3:0] wq,
                            input logic [3:0] oq, input logic [1:0] md);
        i_q_encode = iq; w_q_encode = wq; o_q_encode = oq; i_round_mode = md;
        i_cfg_load = 1'b1;
        @(posedge clk); #1;
        i_cfg_load = 1'b0;
    endtask

    // Presents one beat for a single cycle; returns 1 ns after its handshake edge.
    task automatic send(input logic [255:0] d);
        i_dat = d; i_dat_vld = 1'b1;
        @(posedge clk); #1;
        i_dat_vld = 1'b0;
    endtask

    task automatic test_reset();
        logic [255:0] d;
        i_rst = 1'b1; i_cfg_load = 0; i_dat_vld = 0; i_dat_rdy = 1; i_sat_clr = 0;
        i_dat = '0; i_q_encode = 0; w_q_encode = 0; o_q_encode = 0; i_round_mode = 0;
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if (o_dat_vld !== 1'b0 || o_dat !== '0) begin
            n_fail++; $display("FAIL reset_out vld=%b dat0=%h exp vld=0 dat=0", o_dat_vld, o_dat[15:0]);
        end
        n_tests++;
        if (o_sat_flag !== 1'b0 || o_sat_cnt !== 16'd0) begin
            n_fail++; $display("FAIL reset_sat flag=%b cnt=%h exp 0/0", o_sat_flag, o_sat_cnt);
        end
        i_rst = 1'b0; #1;
        n_tests++;
        if (o_dat_rdy !== 1'b1) begin
            n_fail++; $display("FAIL reset_rdy got=%b exp=1", o_dat_rdy);
        end
        @(posedge clk); #1;
        d = '0; d[7:0] = 8'd5; d[255:248] = 8'hFD;
        send(d);
        @(posedge clk); #1;
        n_tests++;
        if (o_dat_vld !== 1'b1 || o_dat[15:0] !== 16'h0005 || o_dat[511:496] !== 16'hFFFD) begin
            n_fail++;
            $display("FAIL reset_cfg vld=%b l0=%h l31=%h exp 1/0005/fffd", o_dat_vld, o_dat[15:0], o_dat[511:496]);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_shift_up();
        logic [255:0] d;
        logic [15:0]  e;
        load_cfg(4'd4, 4'd4, 4'd4, 2'd0);
        for (int k = 0; k < 32; k++) d[k*8 +: 8] = 8'(k - 16);
        send(d);
        n_tests++;
        if (o_dat_vld !== 1'b0) begin
            n_fail++; $display("FAIL up_latency1 vld=%b exp=0", o_dat_vld);
        end
        @(posedge clk); #1;
        n_tests++;
        if (o_dat_vld !== 1'b1) begin
            n_fail++; $display("FAIL up_latency2 vld=%b exp=1", o_dat_vld);
        end
        for (int k = 0; k < 32; k++) begin
            e = 16'((k - 16) * 16);
            n_tests++;
            if (o_dat[k*16 +: 16] !== e) begin
                n_fail++; $display("FAIL up_lane%0d got=%h exp=%h", k, o_dat[k*16 +: 16], e);
            end
        end
        @(posedge clk); #1;
        n_tests++;
        if (o_dat_vld !== 1'b0 || o_sat_flag !== 1'b0) begin
            n_fail++; $display("FAIL up_drain vld=%b flag=%b exp 0/0", o_dat_vld, o_sat_flag);
        end
    endtask

    task automatic test_saturate();
        logic [255:0] d;
        load_cfg(4'd9, 4'd0, 4'd0, 2'd0);
        d = '0; d[7:0] = 8'h7F; d[15:8] = 8'h80; d[23:16] = 8'h01;
        send(d);
        @(posedge clk); #1;
        n_tests++;
        if (o_dat[63:0] !== 64'h0000_0200_8000_7FFF) begin
            n_fail++; $display("FAIL sat_lanes got=%h exp=0000020080007fff", o_dat[63:0]);
        end
        n_tests++;
        if (o_sat_flag !== 1'b0) begin
            n_fail++; $display("FAIL sat_early flag=%b exp=0", o_sat_flag);
        end
        @(posedge clk); #1;
        n_tests++;
        if (o_sat_flag !== 1'b1 || o_sat_cnt !== 16'd1) begin
            n_fail++; $display("FAIL sat_stats flag=%b cnt=%h exp 1/0001", o_sat_flag, o_sat_cnt);
        end
    endtask

    task automatic test_round();
        logic [255:0] d;
        logic [63:0]  ex [2];
        ex[0] = 64'hFFFE_0001_FFFE_0001;
        ex[1] = 64'hFFFF_0002_FFFF_0001;
        d = '0; d[7:0] = 8'd5; d[15:8] = 8'hFB; d[23:16] = 8'd6; d[31:24] = 8'hFA;
        for (int m = 0; m < 2; m++) begin
            load_cfg(4'd0, 4'd0, 4'd2, 2'(m));
            send(d);
            @(posedge clk); #1;
            n_tests++;
            if (o_dat[63:0] !== ex[m]) begin
                n_fail++; $display("FAIL round_mode%0d got=%h exp=%h", m, o_dat[63:0], ex[m]);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_boundary();
        logic [255:0] d;
        logic [3:0]   qi [4];
        logic [3:0]   qw [4];
        logic [3:0]   qo [4];
        logic [1:0]   md [4];
        logic [23:0]  vin [4];
        logic [47:0]  vex [4];
        qi[0] = 0;  qw[0] = 0;  qo[0] = 8;  md[0] = 1; vin[0] = 24'hFF_7F_80; vex[0] = 48'h0000_0000_0000;
        qi[1] = 0;  qw[1] = 0;  qo[1] = 15; md[1] = 0; vin[1] = 24'hFF_7F_80; vex[1] = 48'hFFFF_0000_FFFF;
        qi[2] = 8;  qw[2] = 0;  qo[2] = 0;  md[2] = 0; vin[2] = 24'h01_7F_80; vex[2] = 48'h0100_7F00_8000;
        qi[3] = 15; qw[3] = 15; qo[3] = 0;  md[3] = 0; vin[3] = 24'hFF_00_01; vex[3] = 48'h8000_0000_7FFF;
        for (int c = 0; c < 4; c++) begin
            load_cfg(qi[c], qw[c], qo[c], md[c]);
            d = '0; d[23:0] = vin[c];
            send(d);
            @(posedge clk); #1;
            n_tests++;
            if (o_dat[47:0] !== vex[c]) begin
                n_fail++; $display("FAIL bound_case%0d got=%h exp=%h", c, o_dat[47:0], vex[c]);
            end
        end
        @(posedge clk); #1;
        n_tests++;
        if (o_sat_cnt !== 16'd2) begin
            n_fail++; $display("FAIL bound_cnt got=%h exp=0002", o_sat_cnt);
        end
    endtask

    task automatic test_back_to_back();
        int sent = 0;
        int got = 0;
        int cyc = 0;
        logic stall = 1'b0;
        logic in_hs;
        logic [511:0] held = '0;
        logic [15:0] e0, e31;
        load_cfg(4'd4, 4'd0, 4'd0, 2'd0);
        while (got < 8 && cyc < 100) begin
            i_dat_vld = (sent < 8);
            i_dat = '0;
            i_dat[7:0] = 8'(sent + 1);
            i_dat[255:248] = 8'(-(sent + 1));
            i_dat_rdy = (cyc % 2 == 0);
            @(negedge clk);
            if (stall) begin
                n_tests++;
                if (o_dat_vld !== 1'b1 || o_dat !== held) begin
                    n_fail++; $display("FAIL b2b_hold cyc=%0d vld=%b l0=%h exp l0=%h", cyc, o_dat_vld, o_dat[15:0], held[15:0]);
                end
            end
            if (o_dat_vld && i_dat_rdy) begin
                e0 = 16'((got + 1) * 16);
                e31 = 16'(-(got + 1) * 16);
                n_tests++;
                if (o_dat[15:0] !== e0 || o_dat[511:496] !== e31) begin
                    n_fail++; $display("FAIL b2b_beat%0d l0=%h l31=%h exp %h/%h", got, o_dat[15:0], o_dat[511:496], e0, e31);
                end
                got++;
            end
            stall = o_dat_vld && !i_dat_rdy;
            held = o_dat;
            in_hs = i_dat_vld && o_dat_rdy;
            @(posedge clk); #1;
            if (in_hs) sent++;
            cyc++;
        end
        i_dat_vld = 1'b0; i_dat_rdy = 1'b1;
        n_tests++;
        if (got != 8 || sent != 8) begin
            n_fail++; $display("FAIL b2b_count got=%0d sent=%0d exp 8/8", got, sent);
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_full_rate();
        for (int c = 0; c < 6; c++) begin
            i_dat_vld = (c < 4);
            i_dat = '0;
            i_dat[7:0] = 8'(c + 1);
            @(negedge clk);
            n_tests++;
            if (o_dat_rdy !== 1'b1 || o_dat_vld !== (c >= 2)) begin
                n_fail++; $display("FAIL rate_c%0d rdy=%b vld=%b exp 1/%b", c, o_dat_rdy, o_dat_vld, c >= 2);
            end
            if (c >= 2) begin
                n_tests++;
                if (o_dat[15:0] !== 16'((c - 1) * 16)) begin
                    n_fail++; $display("FAIL rate_data%0d got=%h exp=%h", c, o_dat[15:0], 16'((c - 1) * 16));
                end
            end
            @(posedge clk); #1;
        end
        i_dat_vld = 1'b0;
    endtask

    task automatic test_cfg_switch();
        logic [255:0] d;
        d = '0; d[7:0] = 8'd3;
        i_dat = d; i_dat_vld = 1'b1;
        @(posedge clk); #1;
        i_dat_vld = 1'b0;
        i_q_encode = 1; w_q_encode = 0; o_q_encode = 0; i_round_mode = 0;
        i_cfg_load = 1'b1;
        @(posedge clk); #1;
        i_cfg_load = 1'b0;
        i_dat_vld = 1'b1;
        @(negedge clk);
        n_tests++;
        if (o_dat_vld !== 1'b1 || o_dat[15:0] !== 16'h0030) begin
            n_fail++; $display("FAIL cfg_beatA vld=%b got=%h exp=0030", o_dat_vld, o_dat[15:0]);
        end
        @(posedge clk); #1;
        i_dat_vld = 1'b0;
        @(posedge clk); #1;
        n_tests++;
        if (o_dat_vld !== 1'b1 || o_dat[15:0] !== 16'h0006) begin
            n_fail++; $display("FAIL cfg_beatB vld=%b got=%h exp=0006", o_dat_vld, o_dat[15:0]);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_sat_clear();
        logic [255:0] d;
        load_cfg(4'd9, 4'd0, 4'd0, 2'd0);
        i_sat_clr = 1'b1;
        @(posedge clk); #1;
        i_sat_clr = 1'b0;
        n_tests++;
        if (o_sat_flag !== 1'b0 || o_sat_cnt !== 16'd0) begin
            n_fail++; $display("FAIL clr_plain flag=%b cnt=%h exp 0/0", o_sat_flag, o_sat_cnt);
        end
        d = '0; d[7:0] = 8'h7F;
        send(d);
        @(posedge clk); #1;
        i_sat_clr = 1'b1;
        @(posedge clk); #1;
        i_sat_clr = 1'b0;
        n_tests++;
        if (o_sat_flag !== 1'b0 || o_sat_cnt !== 16'd0 || o_dat_vld !== 1'b0) begin
            n_fail++; $display("FAIL clr_wins flag=%b cnt=%h vld=%b exp 0/0/0", o_sat_flag, o_sat_cnt, o_dat_vld);
        end
        send(d);
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if (o_sat_flag !== 1'b1 || o_sat_cnt !== 16'd1) begin
            n_fail++; $display("FAIL clr_recount flag=%b cnt=%h exp 1/0001", o_sat_flag, o_sat_cnt);
        end
    endtask

    task automatic test_reset_flight();
        logic [255:0] d;
        logic ghost = 1'b0;
        d = '0; d[7:0] = 8'h7F;
        i_dat = d; i_dat_vld = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        i_dat_vld = 1'b0;
        i_rst = 1'b1;
        #1;
        n_tests++;
        if (o_dat_vld !== 1'b0 || o_dat !== '0 || o_sat_cnt !== 16'd0 || o_sat_flag !== 1'b0) begin
            n_fail++; $display("FAIL rst_flight vld=%b l0=%h cnt=%h flag=%b exp 0/0/0/0", o_dat_vld, o_dat[15:0], o_sat_cnt, o_sat_flag);
        end
        @(posedge clk); #1;
        i_rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (o_dat_vld !== 1'b0) ghost = 1'b1;
        end
        n_tests++;
        if (ghost) begin
            n_fail++; $display("FAIL rst_ghost vld seen=1 exp=0");
        end
        @(posedge clk); #1;
        d = '0; d[7:0] = 8'd5;
        send(d);
        @(posedge clk); #1;
        n_tests++;
        if (o_dat_vld !== 1'b1 || o_dat[15:0] !== 16'h0005) begin
            n_fail++; $display("FAIL rst_cfg vld=%b got=%h exp 1/0005", o_dat_vld, o_dat[15:0]);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_shift_up();
        test_saturate();
        test_round();
        test_boundary();
        test_back_to_back();
        test_full_rate();
        test_cfg_switch();
        test_sat_clear();
        test_reset_flight();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
